player_action_ctrl: RTL and testbench

Per-player action sequencer in front of player_move. Arbitrates raw button inputs, attack requests and incoming hits into a single action state. Drives player_move's move_left/move_right/jump/x_lock controls and consumes its jump_active status. One instance per fighter; the fight top level provides frame_tick and the collision hit pulse.

---
 rtl/player_action_ctrl.sv | 157 +++++++++++++++
 tb/tb_player_action_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer sitting in front of player_move.
// Arbitrates button levels, attack presses and incoming hits into one
// action state, and drives player_move's motion controls from it.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE (0) | standing, no horizontal input
//  WALK (1) | exactly one of left/right held
//  JUMP (2) | jump requested; waiting for or riding out jump_active
//  ATTACK(3)| attack animation, horizontal motion frozen
//  HITSTUN(4)| recoiling from a hit, horizontal motion frozen
module player_action_ctrl #(
    parameter int ATTACK_FRAMES   = 12,
    parameter int HITSTUN_FRAMES  = 20,
    parameter int JUMP_ACK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       hit,
    input  logic       jump_active,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       x_lock,
    output logic       attack_active,
    output logic       hitstun_active,
    output logic [2:0] state
);

    localparam int MAX_AH = (ATTACK_FRAMES > HITSTUN_FRAMES) ? ATTACK_FRAMES : HITSTUN_FRAMES;
    localparam int MAX_F  = (MAX_AH > JUMP_ACK_FRAMES) ? MAX_AH : JUMP_ACK_FRAMES;
    localparam int CW     = $clog2(MAX_F + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WALK    = 3'd1;
    localparam logic [2:0] S_JUMP    = 3'd2;
    localparam logic [2:0] S_ATTACK  = 3'd3;
    localparam logic [2:0] S_HITSTUN = 3'd4;

    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    state_nx;
    logic          seen, seen_nx;
    logic          hit_pending;
    logic          prev_jump, prev_attack;
    logic          jp, ap, dir_l, dir_r;
    logic          enter_jump;
    logic          lock_nx, moving_nx;

    // Next-state decision; only committed on frame_tick.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        seen_nx    = seen;
        enter_jump = 1'b0;
        jp         = btn_jump & ~prev_jump;
        ap         = btn_attack & ~prev_attack;
        dir_l      = btn_left & ~btn_right;
        dir_r      = btn_right & ~btn_left;
        if (hit_pending) begin
            state_nx = S_HITSTUN;
            cnt_nx   = CW'(HITSTUN_FRAMES);
        end else begin
            case (state)
                S_IDLE, S_WALK: begin
                    if (ap) begin
                        state_nx = S_ATTACK;
                        cnt_nx   = CW'(ATTACK_FRAMES);
                    end else if (jp) begin
                        state_nx   = S_JUMP;
                        cnt_nx     = CW'(JUMP_ACK_FRAMES);
                        seen_nx    = 1'b0;
                        enter_jump = 1'b1;
                    end else if (dir_l | dir_r) begin
                        state_nx = S_WALK;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                S_JUMP: begin
                    if (jump_active) begin
                        seen_nx = 1'b1;
                    end else if (seen) begin
                        state_nx = S_IDLE;
                    end else if (cnt <= CW'(1)) begin
                        // player_move never acknowledged the launch
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                S_ATTACK, S_HITSTUN: begin
                    if (cnt <= CW'(1)) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
        lock_nx   = (state_nx == S_ATTACK) | (state_nx == S_HITSTUN);
        moving_nx = (state_nx == S_WALK) | (state_nx == S_JUMP);
    end

    // Hit latch: a pulse on any cycle is held until the next tick consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          hit_pending <= 1'b0;
        else if (hit)        hit_pending <= 1'b1;
        else if (frame_tick) hit_pending <= 1'b0;
    end

    // State, frame counter and button history advance once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            seen        <= 1'b0;
            prev_jump   <= 1'b0;
            prev_attack <= 1'b0;
        end else if (frame_tick) begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            seen        <= seen_nx;
            prev_jump   <= btn_jump;
            prev_attack <= btn_attack;
        end
    end

    // Registered outputs; levels hold between ticks, jump is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump           <= 1'b0;
            move_left      <= 1'b0;
            move_right     <= 1'b0;
            x_lock         <= 1'b0;
            attack_active  <= 1'b0;
            hitstun_active <= 1'b0;
        end else begin
            jump <= frame_tick & enter_jump;
            if (frame_tick) begin
                move_left      <= ~lock_nx & moving_nx & dir_l;
                move_right     <= ~lock_nx & moving_nx & dir_r;
                x_lock         <= lock_nx;
                attack_active  <= (state_nx == S_ATTACK);
                hitstun_active <= (state_nx == S_HITSTUN);
            end
        end
    end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl with hand-computed expectations.
module tb_player_action_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, btn_left, btn_right, btn_jump, btn_attack, hit, jump_active;
    logic       move_left, move_right, jump, x_lock, attack_active, hitstun_active;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int jump_cycles = 0;

    player_action_ctrl #(
        .ATTACK_FRAMES(12), .HITSTUN_FRAMES(20), .JUMP_ACK_FRAMES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .btn_attack(btn_attack), .hit(hit), .jump_active(jump_active),
        .move_left(move_left), .move_right(move_right), .jump(jump),
        .x_lock(x_lock), .attack_active(attack_active),
        .hitstun_active(hitstun_active), .state(state)
    );

    always #5 clk = ~clk;

    // Count clock cycles in which the jump pulse was high.
    always @(posedge clk) if (jump === 1'b1) jump_cycles <= jump_cycles + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_hit();
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; frame_tick = 0; btn_left = 0; btn_right = 1; btn_jump = 0;
        btn_attack = 0; hit = 0; jump_active = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_outs", {move_left, move_right, jump, x_lock, attack_active, hitstun_active}, 0);
        rst_n = 1'b1;

        // 1: walk right, then both directions -> idle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_walk_state", state, 1);
            chk("t1_move_right", move_right, 1);
        end
        btn_left = 1;
        tick();
        chk("t1_both_state", state, 0);
        chk("t1_both_moves", {move_left, move_right}, 0);

        // 2: jump with air steering left
        btn_right = 0; btn_jump = 1;
        tick();
        chk("t2_jump_state", state, 2);
        chk("t2_jump_ml", move_left, 1);
        chk("t2_pulse_cnt", jump_cycles, 1);
        jump_active = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_air_state", state, 2);
            chk("t2_air_ml", move_left, 1);
        end
        jump_active = 0;
        tick();
        chk("t2_land_state", state, 0);
        tick();
        chk("t2_held_walk", state, 1);
        chk("t2_no_rejump", jump_cycles, 1);

        // 3: attack from walk, second press ignored
        btn_jump = 0; btn_attack = 1;
        tick();
        chk("t3_atk_state", state, 3);
        chk("t3_atk_lock", {x_lock, attack_active, move_left}, 3'b110);
        for (int i = 1; i <= 11; i++) begin
            if (i == 3) btn_attack = 0;
            if (i == 5) btn_attack = 1;
            tick();
            chk("t3_atk_hold", state, 3);
            chk("t3_atk_ml", move_left, 0);
        end
        tick();
        chk("t3_atk_end", state, 0);
        chk("t3_end_lock", x_lock, 0);

        // 4: hit during attack, re-hit restarts hitstun
        btn_attack = 0; btn_left = 0;
        tick();
        btn_attack = 1;
        tick();
        chk("t4_atk_state", state, 3);
        pulse_hit();
        tick();
        chk("t4_hs_state", state, 4);
        chk("t4_hs_flags", {x_lock, attack_active, hitstun_active}, 3'b101);
        for (int i = 1; i <= 24; i++) begin
            if (i == 5) pulse_hit();
            tick();
            chk("t4_hs_hold", state, 4);
        end
        tick();
        chk("t4_hs_end", state, 0);
        chk("t4_end_flags", {x_lock, hitstun_active}, 0);

        // 5: hit outranks simultaneous attack and jump presses
        btn_attack = 0;
        tick();
        pulse_hit();
        btn_attack = 1; btn_jump = 1;
        tick();
        chk("t5_hs_wins", state, 4);
        chk("t5_no_pulse", jump_cycles, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_hs_end", state, 0);
        chk("t5_no_pulse2", jump_cycles, 1);

        // 6: unacknowledged jump abandons after 4 frames
        btn_attack = 0; btn_jump = 0;
        tick();
        btn_jump = 1;
        tick();
        chk("t6_jump_state", state, 2);
        chk("t6_pulse_cnt", jump_cycles, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_wait_state", state, 2);
        end
        tick();
        chk("t6_abandon", state, 0);

        // 6b: reset in the jump pulse cycle
        btn_jump = 0;
        tick();
        btn_jump = 1; btn_left = 1;
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        chk("t6_pre_rst_jump", jump, 1);
        chk("t6_pre_rst_state", state, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_outs", {move_left, move_right, jump, x_lock, attack_active, hitstun_active}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
